// File: rtl/lrc_stream_check.sv
// lrc_stream_check: streaming left-right disparity consistency checker.
// Keeps the last 2**BWIDTH right disparities of the row in a circular buffer,
// checks each left disparity against its matched right disparity and emits
// {status, disparity}. Define LRC_STATS_EN to add per-row error statistics.
module lrc_stream_check #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned AWIDTH = 11,
    parameter int unsigned BWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clken,
    input  logic [AWIDTH-1:0] width,
    input  logic [8:0]        range,
    input  logic [3:0]        lrc_param,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] disp_L,
    input  logic [DWIDTH-1:0] disp_R,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH+1:0] disp_out,
    output logic              row_end
`ifdef LRC_STATS_EN
    ,
    output logic [AWIDTH:0]   err_count,
    output logic              err_valid
`endif
);

    localparam int unsigned DEPTH = 2 ** BWIDTH;
    localparam int unsigned RW    = (DWIDTH > 9) ? DWIDTH : 9;
    localparam int unsigned XW    = (AWIDTH > DWIDTH) ? AWIDTH : DWIDTH;
    localparam int unsigned EW    = (DWIDTH + 1 > 4) ? DWIDTH + 1 : 4;

    logic [DWIDTH-1:0] mem [DEPTH];

    logic              advance;
    logic              accept;

    logic [AWIDTH-1:0] x;
    logic [AWIDTH-1:0] width_q;
    logic [BWIDTH-1:0] wp;

    logic [AWIDTH-1:0] wsel_c;
    logic [AWIDTH-1:0] wlast_c;
    logic              last_c;
    logic              oor_c;
    logic              border_c;
    logic [BWIDTH-1:0] raddr_c;

    logic              s1_valid;
    logic [DWIDTH-1:0] s1_dl;
    logic [DWIDTH-1:0] s1_dr;
    logic              s1_oor;
    logic              s1_border;
    logic [1:0]        s1_mode;
    logic [3:0]        s1_t;
    logic              s1_last;

    logic              dl_ge_c;
    logic [DWIDTH:0]   diff_c;
    logic [DWIDTH-1:0] min_c;
    logic              mism_c;
    logic [1:0]        status_c;
    logic [DWIDTH-1:0] field_c;

    // Whole pipeline moves together; it stalls only on output backpressure or clken.
    assign advance  = clken && (!out_valid || out_ready);
    assign in_ready = advance && !rst;
    assign accept   = in_valid && in_ready;

    // S1 combinational: row position, read address and range/border tests.
    always_comb begin
        wsel_c   = (x == '0) ? width : width_q;
        wlast_c  = (wsel_c == '0) ? '0 : wsel_c - AWIDTH'(1);
        last_c   = (x == wlast_c);
        oor_c    = RW'(disp_L) > RW'(range);
        border_c = XW'(x) < XW'(disp_L);
        raddr_c  = wp - BWIDTH'(disp_L);
    end

    // Right-disparity buffer with registered read; disp_L==0 forwards the incoming disp_R.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wp] <= disp_R;
            if (disp_L == '0) begin
                s1_dr <= disp_R;
            end else if (!border_c) begin
                s1_dr <= mem[raddr_c];
            end
        end
    end

    // Column counter, write pointer and row width capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x       <= '0;
            wp      <= '0;
            width_q <= '0;
        end else if (accept) begin
            x  <= last_c ? '0 : x + AWIDTH'(1);
            wp <= wp + BWIDTH'(1);
            if (x == '0) begin
                width_q <= width;
            end
        end
    end

    // S1 pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_dl     <= '0;
            s1_oor    <= 1'b0;
            s1_border <= 1'b0;
            s1_mode   <= '0;
            s1_t      <= '0;
            s1_last   <= 1'b0;
        end else if (advance) begin
            s1_valid <= accept;
            if (accept) begin
                s1_dl     <= disp_L;
                s1_oor    <= oor_c;
                s1_border <= border_c;
                s1_mode   <= mode;
                s1_t      <= lrc_param;
                s1_last   <= last_c;
            end
        end
    end

    // S2 combinational: compare, status priority and output field select.
    always_comb begin
        dl_ge_c  = s1_dl >= s1_dr;
        diff_c   = dl_ge_c ? ({1'b0, s1_dl} - {1'b0, s1_dr})
                           : ({1'b0, s1_dr} - {1'b0, s1_dl});
        min_c    = dl_ge_c ? s1_dr : s1_dl;
        mism_c   = EW'(diff_c) > EW'(s1_t);
        status_c = 2'b00;
        field_c  = '1;
        if (s1_oor) begin
            status_c = 2'b11;
        end else if (s1_border) begin
            status_c = 2'b10;
        end else if (mism_c) begin
            status_c = 2'b01;
        end
        case (s1_mode)
            2'd1:    field_c = (status_c == 2'b00) ? min_c : '1;
            2'd2:    field_c = s1_dl;
            default: field_c = (status_c == 2'b00) ? s1_dl : '1;
        endcase
    end

    // S2 output register; holds while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            disp_out  <= '0;
            row_end   <= 1'b0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                disp_out <= {status_c, field_c};
                row_end  <= s1_last;
            end
        end
    end

`ifdef LRC_STATS_EN
    logic [AWIDTH:0] err_acc;
    logic            out_xfer;
    logic            out_bad;

    assign out_xfer = advance && out_valid;
    assign out_bad  = (disp_out[DWIDTH+1:DWIDTH] != 2'b00);

    // Per-row count of non-pass outputs, published for one cycle after row_end leaves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_acc   <= '0;
            err_count <= '0;
            err_valid <= 1'b0;
        end else if (clken) begin
            err_valid <= 1'b0;
            err_count <= '0;
            if (out_xfer) begin
                if (row_end) begin
                    err_count <= err_acc + (AWIDTH + 1)'(out_bad);
                    err_valid <= 1'b1;
                    err_acc   <= '0;
                end else begin
                    err_acc <= err_acc + (AWIDTH + 1)'(out_bad);
                end
            end
        end
    end
`endif

endmodule
